crosswalk_request_conditioner: RTL

CROSSWALK_REQUEST_CONDITIONER -- requirements
Module: crosswalk_request_conditioner

---
 rtl/crosswalk_request_conditioner_pkg.sv | 26 ++
 rtl/crosswalk_request_conditioner_xwalk_channel.sv | 101 ++++++++++
 rtl/crosswalk_request_conditioner.sv | 47 ++++
 3 files changed

// File: rtl/crosswalk_request_conditioner_pkg.sv
// Shared traffic-light constants: intersection phases, pedestrian debounce
// states and the default debounce depth.
package crosswalk_request_conditioner_pkg;

   localparam int DB_TICKS_DEFAULT = 8;

   typedef enum logic [1:0] {
      LT_GREEN   = 2'd0,
      LT_YELLOW  = 2'd1,
      LT_RED     = 2'd2,
      LT_ALL_RED = 2'd3
   } light_state_e;

   typedef enum logic [1:0] {
      DB_IDLE = 2'd0,
      DB_ARM  = 2'd1,
      DB_HELD = 2'd2,
      DB_REL  = 2'd3
   } db_state_e;

   // One spare bit over log2 so DB_TICKS-1 always fits.
   function automatic int db_cnt_w(input int ticks);
      return $clog2(ticks) + 1;
   endfunction

endpackage

// File: rtl/crosswalk_request_conditioner_xwalk_channel.sv
// One pedestrian channel: button/green synchronizers, tick-based debounce,
// latched crosswalk request cleared by the end of a green phase, press counter.
module xwalk_channel
   import crosswalk_request_conditioner_pkg::*;
#(
   parameter int DB_TICKS = DB_TICKS_DEFAULT,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             btn,
   input  logic             grn,
   output logic             crosswalk,
   output logic [CNT_W-1:0] press_cnt
);

   localparam int            CW       = db_cnt_w(DB_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

   logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic             grn_s1_q, grn_s1_d, grn_s2_q, grn_s2_d;
   logic             grn_dly_q, grn_dly_d, grn_fall_q, grn_fall_d;
   db_state_e        state_q, state_d;
   logic [CW-1:0]    db_cnt_q, db_cnt_d;
   logic             xwalk_q, xwalk_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic             accept;

   always_comb begin
      btn_s1_d   = btn;
      btn_s2_d   = btn_s1_q;
      grn_s1_d   = grn;
      grn_s2_d   = grn_s1_q;
      grn_dly_d  = grn_s2_q;
      grn_fall_d = grn_dly_q & ~grn_s2_q;
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      accept     = 1'b0;
      case (state_q)
         DB_IDLE: if (btn_s2_q) begin
            state_d  = DB_ARM;
            db_cnt_d = '0;
         end
         DB_ARM: begin
            if (!btn_s2_q) state_d = DB_IDLE;
            else if (tick) begin
               if (db_cnt_q == CNT_LAST) begin
                  state_d = DB_HELD;
                  accept  = 1'b1;
               end else db_cnt_d = db_cnt_q + CW'(1);
            end
         end
         DB_HELD: if (!btn_s2_q) begin
            state_d  = DB_REL;
            db_cnt_d = '0;
         end
         DB_REL: begin
            if (btn_s2_q) state_d = DB_HELD;
            else if (tick) begin
               if (db_cnt_q == CNT_LAST) state_d = DB_IDLE;
               else db_cnt_d = db_cnt_q + CW'(1);
            end
         end
         default: state_d = DB_IDLE;
      endcase
      // A new press outranks a green-phase clear landing on the same edge.
      xwalk_d     = accept ? 1'b1 : (grn_fall_q ? 1'b0 : xwalk_q);
      press_cnt_d = (accept && (press_cnt_q != '1)) ? press_cnt_q + CNT_W'(1) : press_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_s1_q    <= 1'b0;
         btn_s2_q    <= 1'b0;
         grn_s1_q    <= 1'b0;
         grn_s2_q    <= 1'b0;
         grn_dly_q   <= 1'b0;
         grn_fall_q  <= 1'b0;
         state_q     <= DB_IDLE;
         db_cnt_q    <= '0;
         xwalk_q     <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         btn_s1_q    <= btn_s1_d;
         btn_s2_q    <= btn_s2_d;
         grn_s1_q    <= grn_s1_d;
         grn_s2_q    <= grn_s2_d;
         grn_dly_q   <= grn_dly_d;
         grn_fall_q  <= grn_fall_d;
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         xwalk_q     <= xwalk_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign crosswalk = xwalk_q;
   assign press_cnt = press_cnt_q;

endmodule

// File: rtl/crosswalk_request_conditioner.sv
// Two independent pedestrian request channels (north, west) feeding the
// intersection's crosswalk inputs; WAIT lamps mirror the latched requests.
module crosswalk_request_conditioner
   import crosswalk_request_conditioner_pkg::*;
#(
   parameter int DB_TICKS = DB_TICKS_DEFAULT,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             btn_0,
   input  logic             btn_1,
   input  logic             grn_0,
   input  logic             grn_1,
   output logic             crosswalk_0,
   output logic             crosswalk_1,
   output logic             wait_lamp_0,
   output logic             wait_lamp_1,
   output logic [CNT_W-1:0] press_cnt_0,
   output logic [CNT_W-1:0] press_cnt_1
);

   xwalk_channel #(.DB_TICKS(DB_TICKS), .CNT_W(CNT_W)) u_ch0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .btn       (btn_0),
      .grn       (grn_0),
      .crosswalk (crosswalk_0),
      .press_cnt (press_cnt_0)
   );

   xwalk_channel #(.DB_TICKS(DB_TICKS), .CNT_W(CNT_W)) u_ch1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .btn       (btn_1),
      .grn       (grn_1),
      .crosswalk (crosswalk_1),
      .press_cnt (press_cnt_1)
   );

   assign wait_lamp_0 = crosswalk_0;
   assign wait_lamp_1 = crosswalk_1;

endmodule
